grad_window: RTL and testbench

- Upstream neighbour fetcher for the HOG pipeline. Accepts a raster-order grayscale pixel stream, one pixel per cycle.
- For every pixel position it emits the 4-neighbourhood {left, right, top, bottom} as one packed word. This is exactly the 4-pixel input word that the gradient/magnitude stage consumes.
- Buffers two image rows internally.
- Borders are handled by replicating the centre pixel, so the frame produces exactly IMG_W*IMG_H output words.

---
 rtl/hog_pkg.sv | 37 +++
 rtl/line_delay.sv | 32 +++
 rtl/grad_window.sv | 129 ++++++++++++
 tb/tb_grad_window.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hog_pkg.sv
// Shared definitions for the HOG front end: pixel width default, neighbour
// slot numbering inside the packed neighbourhood word, and the FSM state type.
package hog_pkg;

  localparam int PIX_W_DEF = 8;

  localparam int NB_LEFT   = 3;
  localparam int NB_RIGHT  = 2;
  localparam int NB_TOP    = 1;
  localparam int NB_BOTTOM = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Bit offset of a neighbour slot for a given pixel width.
  function automatic int nb_lsb(input int slot, input int pix_w);
    return slot * pix_w;
  endfunction

  function automatic logic [4*PIX_W_DEF-1:0] pack_nb(
    input logic [PIX_W_DEF-1:0] left,
    input logic [PIX_W_DEF-1:0] right,
    input logic [PIX_W_DEF-1:0] top,
    input logic [PIX_W_DEF-1:0] bottom
  );
    logic [4*PIX_W_DEF-1:0] word;
    word = '0;
    word[NB_LEFT*PIX_W_DEF   +: PIX_W_DEF] = left;
    word[NB_RIGHT*PIX_W_DEF  +: PIX_W_DEF] = right;
    word[NB_TOP*PIX_W_DEF    +: PIX_W_DEF] = top;
    word[NB_BOTTOM*PIX_W_DEF +: PIX_W_DEF] = bottom;
    return word;
  endfunction

endpackage

// File: rtl/line_delay.sv
// DEPTH-deep pixel shift line; advances only when en is high.
// Exposes the oldest entry plus one intermediate tap.
module line_delay
  import hog_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int DEPTH = 4,
  parameter int TAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] tap,
  output logic [PIX_W-1:0] last
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign tap  = mem[TAP];
  assign last = mem[DEPTH-1];

endmodule

// File: rtl/grad_window.sv
// Raster-stream 4-neighbourhood fetcher with centre-replicated borders.
// The last image row is drained by a FLUSH phase that stalls the input.
module grad_window
  import hog_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 160,
  parameter int IMG_H = 96
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [PIX_W-1:0]   i_pixel,
  output logic               i_ready,
  output logic               o_valid,
  output logic [4*PIX_W-1:0] o_data,
  output logic               o_frame_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic             ready_q;
  logic             accept, step, emit, frame_end, row_end;
  logic [PIX_W-1:0] line_in, centre, right_raw, left_raw, top_raw;
  logic [PIX_W-1:0] nb_left, nb_right, nb_top, nb_bottom;

  assign accept  = i_valid & ready_q;
  assign i_ready = ready_q;
  assign row_end = (x_q == X_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (accept && row_end && (y_q == Y_LAST)) state_d = ST_FLUSH;
      ST_FLUSH: if (row_end) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // In RUN the counters track the accepted pixel; outputs lag by one row.
  // In FLUSH x walks the last row while y sits at 0, ready for the next frame.
  always_comb begin
    step      = 1'b0;
    emit      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_RUN: begin
        step = accept;
        emit = accept && (y_q != '0);
      end
      ST_FLUSH: begin
        step      = 1'b1;
        emit      = 1'b1;
        frame_end = row_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_d == ST_RUN);
      if (step) begin
        x_q <= row_end ? '0 : x_q + 1'b1;
        if ((state_q == ST_RUN) && row_end)
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end
    end
  end

  assign line_in = (state_q == ST_FLUSH) ? '0 : i_pixel;

  line_delay #(.PIX_W(PIX_W), .DEPTH(IMG_W), .TAP(IMG_W - 2)) u_row_near (
    .clk  (clk),
    .rst  (rst),
    .en   (step),
    .din  (line_in),
    .tap  (right_raw),
    .last (centre)
  );

  line_delay #(.PIX_W(PIX_W), .DEPTH(IMG_W), .TAP(0)) u_row_far (
    .clk  (clk),
    .rst  (rst),
    .en   (step),
    .din  (centre),
    .tap  (left_raw),
    .last (top_raw)
  );

  assign nb_left   = (x_q == '0) ? centre : left_raw;
  assign nb_right  = row_end ? centre : right_raw;
  assign nb_top    = ((state_q == ST_RUN) && (y_q == Y_ONE)) ? centre : top_raw;
  assign nb_bottom = (state_q == ST_FLUSH) ? centre : i_pixel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_data       <= '0;
    end else begin
      o_valid      <= emit;
      o_frame_done <= frame_end;
      if (emit) begin
        o_data[nb_lsb(NB_LEFT, PIX_W)   +: PIX_W] <= nb_left;
        o_data[nb_lsb(NB_RIGHT, PIX_W)  +: PIX_W] <= nb_right;
        o_data[nb_lsb(NB_TOP, PIX_W)    +: PIX_W] <= nb_top;
        o_data[nb_lsb(NB_BOTTOM, PIX_W) +: PIX_W] <= nb_bottom;
      end
    end
  end

endmodule

// File: tb/tb_grad_window.sv
// Directed + randomized bench for grad_window on a 4x3 frame, checked against
// a frame-array reference model of the clamped 4-neighbourhood.
module tb_grad_window;
  import hog_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_pixel = '0;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_frame_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  pix [N];
  logic [31:0] obs [N];

  grad_window #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_pixel      (i_pixel),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input int k);
    int x, y;
    logic [7:0] c, l, r, t, b;
    x = k % W;
    y = k / W;
    c = pix[k];
    l = (x == 0)     ? c : pix[k-1];
    r = (x == W - 1) ? c : pix[k+1];
    t = (y == 0)     ? c : pix[k-W];
    b = (y == H - 1) ? c : pix[k+W];
    return pack_nb(l, r, t, b);
  endfunction

  task automatic fill_index(input int base);
    for (int i = 0; i < N; i++) pix[i] = 8'(base + i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
  endtask

  // stall: 0 = continuous valid, 1 = valid pattern 1,0,0, 2 = random gaps
  task automatic run_frame(input int stall);
    int acc, flush_left, cyc, exp_k, n_out;
    bit done, was_acc;
    acc = 0; flush_left = 0; cyc = 0; n_out = 0; done = 0;
    while (!done && cyc < 400) begin
      cyc++;
      if (acc < N) begin
        case (stall)
          0:       i_valid = 1'b1;
          1:       i_valid = (cyc % 3 == 1);
          default: i_valid = ($urandom_range(0, 2) != 0);
        endcase
        i_pixel = pix[acc];
      end else begin
        i_valid = 1'b0;
        i_pixel = 8'($urandom);
      end
      was_acc = i_valid && i_ready;
      @(posedge clk);
      #1;
      exp_k = -1;
      if (was_acc) begin
        if (acc >= W) exp_k = acc - W;
        acc++;
        if (acc == N) flush_left = W;
      end else if (flush_left > 0) begin
        exp_k = N - flush_left;
        flush_left--;
      end
      check("o_valid", 32'(o_valid), 32'(exp_k >= 0));
      check("i_ready", 32'(i_ready), 32'(flush_left == 0));
      if (exp_k >= 0) begin
        n_out++;
        obs[exp_k] = o_data;
        check($sformatf("o_data k=%0d", exp_k), o_data, model(exp_k));
        check("o_frame_done", 32'(o_frame_done), 32'(exp_k == N - 1));
        if (exp_k == N - 1) done = 1;
      end else begin
        check("o_frame_done idle", 32'(o_frame_done), 32'd0);
      end
    end
    check("frame completed", 32'(done), 32'd1);
    check("output count", 32'(n_out), 32'(N));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset o_data", o_data, 32'd0);
    check("reset o_frame_done", 32'(o_frame_done), 32'd0);
    check("reset i_ready", 32'(i_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("i_ready after reset", 32'(i_ready), 32'd1);

    // basic frame with index pixels
    fill_index(0);
    run_frame(0);
    check("basic k0", obs[0], 32'h0001_0004);
    check("basic k5", obs[5], 32'h0406_0109);
    check("basic k11", obs[11], 32'h0A0B_070B);

    // back-to-back frame, top row must not see the previous frame
    fill_index(100);
    run_frame(0);
    check("b2b k0", obs[0], 32'h6465_6468);

    // 1,0,0 valid pattern reproduces the basic frame
    fill_index(0);
    run_frame(1);
    check("stall k0", obs[0], 32'h0001_0004);
    check("stall k5", obs[5], 32'h0406_0109);
    check("stall k11", obs[11], 32'h0A0B_070B);

    for (int f = 0; f < 6; f++) begin
      fill_random();
      run_frame(f % 3);
    end

    // mid-frame reset after input 6
    fill_index(0);
    for (int i = 0; i < 7; i++) begin
      i_valid = 1'b1;
      i_pixel = pix[i];
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async rst o_valid", 32'(o_valid), 32'd0);
    check("async rst o_data", o_data, 32'd0);
    check("async rst i_ready", 32'(i_ready), 32'd0);
    check("async rst o_frame_done", 32'(o_frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("i_ready after mid reset", 32'(i_ready), 32'd1);
    run_frame(0);
    check("post-reset k0", obs[0], 32'h0001_0004);
    check("post-reset k5", obs[5], 32'h0406_0109);
    check("post-reset k11", obs[11], 32'h0A0B_070B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
